// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: stall/flush generation,
// EX-stage forwarding selects, and instruction/data memory wait tracking.
module hazard_ctrl #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned DMEM_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              memtoreg_e,
  input  logic              pcsrc_e,
  input  logic              imem_ready,
  input  logic              dmem_req_m,
  input  logic              dmem_ready,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              dmem_timeout
);

  localparam int unsigned CW = $clog2(DMEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, DWAIT, TIMEOUT} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   wait_cnt, wait_cnt_nx;
  logic            drop_pending, drop_nx;
  logic            timeout_nx;
  logic            mem_stall, lw_stall, if_wait;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              we_m,
    input logic [REG_AW-1:0] dst_m,
    input logic              we_w,
    input logic [REG_AW-1:0] dst_w
  );
    if (we_m && dst_m != '0 && dst_m == rs)      return 2'b10;
    else if (we_w && dst_w != '0 && dst_w == rs) return 2'b01;
    else                                         return 2'b00;
  endfunction

  assign mem_stall = dmem_req_m && !dmem_ready && (state != TIMEOUT);
  assign lw_stall  = memtoreg_e && rd_e != '0 && (rd_e == rs1_d || rd_e == rs2_d);
  assign if_wait   = !imem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      drop_pending <= 1'b0;
      dmem_timeout <= 1'b0;
    end else begin
      state        <= state_nx;
      wait_cnt     <= wait_cnt_nx;
      drop_pending <= drop_nx;
      dmem_timeout <= timeout_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    timeout_nx  = dmem_timeout;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nx    = DWAIT;
          wait_cnt_nx = CW'(1);
        end
      end
      DWAIT: begin
        if (dmem_ready) begin
          state_nx    = RUN;
          wait_cnt_nx = '0;
        end else if (wait_cnt == CW'(DMEM_TIMEOUT - 1)) begin
          state_nx   = TIMEOUT;
          timeout_nx = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + CW'(1);
        end
      end
      TIMEOUT: timeout_nx = 1'b1;
      default: state_nx = RUN;
    endcase

    // a redirect while the fetch is outstanding always implies imem_ready=0, so set wins
    if (pcsrc_e && if_wait && !mem_stall) drop_nx = 1'b1;
    else if (imem_ready)                  drop_nx = 1'b0;
    else                                  drop_nx = drop_pending;
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (!rst_n) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else begin
      fwd_a_e = fwd_sel(rs1_e, regwrite_m, rd_m, regwrite_w, rd_w);
      fwd_b_e = fwd_sel(rs2_e, regwrite_m, rd_m, regwrite_w, rd_w);
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else if (pcsrc_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else if (if_wait) begin
        stall_f = 1'b1;
        flush_d = 1'b1;
      end else if (drop_pending) begin
        flush_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a behavioural model checked every cycle plus
// hand-computed literal expectations on each scenario.
module tb_hazard_ctrl;
  localparam int AW = 5;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          regwrite_m, regwrite_w, memtoreg_e, pcsrc_e;
  logic          imem_ready, dmem_req_m, dmem_ready;
  logic          stall_f, stall_d, stall_e, stall_m;
  logic          flush_d, flush_e, flush_w;
  logic [1:0]    fwd_a_e, fwd_b_e;
  logic          dmem_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.REG_AW(AW), .DMEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .pcsrc_e(pcsrc_e),
    .imem_ready(imem_ready), .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .dmem_timeout(dmem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: length of the current data wait, timeout seen, stale fetch to drop.
  int m_cnt  = 0;
  bit m_to   = 1'b0;
  bit m_drop = 1'b0;

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
    if (!rst_n) return 2'b00;
    if (regwrite_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (regwrite_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  function automatic logic [6:0] m_ctl();
    bit ms, lw;
    if (!rst_n) return 7'b0000111;
    ms = dmem_req_m && !dmem_ready && !m_to;
    lw = memtoreg_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    if (ms)          return 7'b1111001;
    if (pcsrc_e)     return 7'b0000110;
    if (lw)          return 7'b1100010;
    if (!imem_ready) return 7'b1000100;
    if (m_drop)      return 7'b0000100;
    return 7'b0000000;
  endfunction

  function automatic logic [7:0] dut_ctl();
    return {1'b0, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_to   <= 1'b0;
      m_drop <= 1'b0;
    end else begin
      if (!m_to) begin
        if (m_cnt == 0) begin
          if (dmem_req_m && !dmem_ready) m_cnt <= 1;
        end else if (dmem_ready) m_cnt <= 0;
        else if (m_cnt + 1 == T) m_to <= 1'b1;
        else m_cnt <= m_cnt + 1;
      end
      if (pcsrc_e && !imem_ready && !(dmem_req_m && !dmem_ready && !m_to)) m_drop <= 1'b1;
      else if (imem_ready) m_drop <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("model ctl",   dut_ctl(),             {1'b0, m_ctl()});
    chk("model fwd_a", {6'b0, fwd_a_e},       {6'b0, m_fwd(rs1_e)});
    chk("model fwd_b", {6'b0, fwd_b_e},       {6'b0, m_fwd(rs2_e)});
    chk("model tmo",   {7'b0, dmem_timeout},  {7'b0, m_to});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {regwrite_m, regwrite_w, memtoreg_e, pcsrc_e} = '0;
    imem_ready = 1'b1;
    dmem_req_m = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic fwd_vec(input string name,
                         input logic [AW-1:0] rdm, input logic rwm,
                         input logic [AW-1:0] rdw, input logic rww,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic [1:0] ea, input logic [1:0] eb);
    cyc();
    rd_m = rdm; regwrite_m = rwm; rd_w = rdw; regwrite_w = rww; rs1_e = r1; rs2_e = r2;
    #2;
    chk({name, " a"}, {6'b0, fwd_a_e}, {6'b0, ea});
    chk({name, " b"}, {6'b0, fwd_b_e}, {6'b0, eb});
  endtask

  initial begin
    int nst;
    set_idle();
    regwrite_m = 1'b1; rd_m = 5'd5; rs1_e = 5'd5;
    #1 rst_n = 1'b0;
    #2;
    chk("reset ctl", dut_ctl(), 8'b0000_0111);
    chk("reset fwd", {6'b0, fwd_a_e}, 8'h00);
    chk("reset tmo", {7'b0, dmem_timeout}, 8'h00);
    #9 rst_n = 1'b1;
    #1;
    chk("post-reset fwd", {6'b0, fwd_a_e}, 8'h02);
    chk("post-reset ctl", dut_ctl(), 8'h00);

    fwd_vec("fwd mem prio", 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 5'd9, 2'b10, 2'b00);
    fwd_vec("fwd rd_m zero", 5'd0, 1'b1, 5'd5, 1'b1, 5'd5, 5'd9, 2'b01, 2'b00);
    fwd_vec("fwd x0", 5'd0, 1'b1, 5'd0, 1'b1, 5'd5, 5'd0, 2'b00, 2'b00);
    fwd_vec("fwd wb b", 5'd7, 1'b0, 5'd7, 1'b1, 5'd3, 5'd7, 2'b00, 2'b01);
    fwd_vec("fwd mem both", 5'd7, 1'b1, 5'd2, 1'b1, 5'd7, 5'd7, 2'b10, 2'b10);
    fwd_vec("fwd no we", 5'd4, 1'b0, 5'd4, 1'b0, 5'd4, 5'd4, 2'b00, 2'b00);

    cyc(); set_idle();
    memtoreg_e = 1'b1; rd_e = 5'd3; rs2_d = 5'd3; #2;
    chk("load-use", dut_ctl(), 8'b0110_0010);
    cyc(); memtoreg_e = 1'b0; #2;
    chk("load-use gone", dut_ctl(), 8'h00);
    cyc(); memtoreg_e = 1'b1; pcsrc_e = 1'b1; #2;
    chk("load-use+redirect", dut_ctl(), 8'b0000_0110);
    cyc(); pcsrc_e = 1'b0; rd_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0; #2;
    chk("load x0 no stall", dut_ctl(), 8'h00);

    cyc(); set_idle();
    dmem_req_m = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin pcsrc_e = 1'b1; imem_ready = 1'b0; end
      else begin pcsrc_e = 1'b0; imem_ready = 1'b1; end
      #2;
      chk("data wait", dut_ctl(), 8'b0111_1001);
      if (i < 3) cyc();
    end
    cyc(); pcsrc_e = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; #2;
    chk("data done", dut_ctl(), 8'h00);
    cyc(); #2;
    chk("single-cycle access", dut_ctl(), 8'h00);

    cyc(); set_idle();
    imem_ready = 1'b0; pcsrc_e = 1'b1; #2;
    chk("redirect", dut_ctl(), 8'b0000_0110);
    cyc(); pcsrc_e = 1'b0; #2;
    chk("fetch wait", dut_ctl(), 8'b0100_0100);
    cyc(); imem_ready = 1'b1; #2;
    chk("drop stale fetch", dut_ctl(), 8'b0000_0100);
    cyc(); #2;
    chk("drop cleared", dut_ctl(), 8'h00);

    cyc(); set_idle();
    dmem_req_m = 1'b1;
    cyc();
    #1 rst_n = 1'b0;
    #1;
    chk("async reset ctl", dut_ctl(), 8'b0000_0111);
    #1 rst_n = 1'b1; dmem_req_m = 1'b0;

    cyc();
    dmem_req_m = 1'b1; dmem_ready = 1'b0;
    #2;
    nst = 0;
    while (stall_m && nst < 20) begin
      nst++;
      @(posedge clk);
      #3;
    end
    chk("timeout stall len", 8'(nst), 8'd8);
    chk("timeout flag", {7'b0, dmem_timeout}, 8'h01);
    chk("timeout drains", dut_ctl(), 8'h00);
    cyc(); memtoreg_e = 1'b1; rd_e = 5'd6; rs1_d = 5'd6; #2;
    chk("timeout load-use", dut_ctl(), 8'b0110_0010);
    repeat (3) cyc();
    chk("timeout sticky", {7'b0, dmem_timeout}, 8'h01);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    chk("timeout cleared", {7'b0, dmem_timeout}, 8'h00);
    set_idle();
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core.
- Generates the per-stage stall (en) and flush (clear) inputs that drive the control-signal pipeline registers (ctrl_reg) and the datapath pipeline registers.
- Generates EX-stage forwarding selects.
- Tracks multi-cycle instruction- and data-memory waits, plus fetch redirects that occur while an instruction fetch is still outstanding.

Parameters:
- REG_AW, 5, register-address width.
- DMEM_TIMEOUT, 256, maximum cycles a data access may wait before the sticky error is set.

Ports:
- clk, input, 1, clock; rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- rs1_d, input, REG_AW, source register 1 of the instruction in decode.
- rs2_d, input, REG_AW, source register 2 of the instruction in decode.
- rs1_e, input, REG_AW, source register 1 of the instruction in execute.
- rs2_e, input, REG_AW, source register 2 of the instruction in execute.
- rd_e, input, REG_AW, destination register in execute.
- rd_m, input, REG_AW, destination register in memory.
- rd_w, input, REG_AW, destination register in writeback.
- regwrite_m, input, 1, memory-stage instruction writes the register file.
- regwrite_w, input, 1, writeback-stage instruction writes the register file.
- memtoreg_e, input, 1, execute-stage instruction is a load.
- pcsrc_e, input, 1, branch taken, jal or jalr resolved in execute.
- imem_ready, input, 1, instruction fetch completes this cycle.
- dmem_req_m, input, 1, memory stage issues a load or store.
- dmem_ready, input, 1, data access completes this cycle.
- stall_f, output, 1, hold PC.
- stall_d, output, 1, hold IF/ID register.
- stall_e, output, 1, hold ID/EX register.
- stall_m, output, 1, hold EX/MEM register.
- flush_d, output, 1, clear IF/ID register.
- flush_e, output, 1, clear ID/EX register.
- flush_w, output, 1, clear MEM/WB register.
- fwd_a_e, output, 2, operand A select: 00 = register file, 01 = WB result, 10 = MEM ALU result.
- fwd_b_e, output, 2, operand B select, same encoding as fwd_a_e.
- dmem_timeout, output, 1, sticky error flag.

Behaviour:

Reset:
- rst_n low asynchronously forces: state=RUN, wait_cnt=0, drop_pending=0, dmem_timeout=0.
- While rst_n is low, outputs are: all stall_* = 0, flush_d = flush_e = flush_w = 1, fwd_* = 00.

Forwarding (combinational, zero latency):
- fwd_a_e = 10 if regwrite_m && rd_m!=0 && rd_m==rs1_e.
- Otherwise fwd_a_e = 01 if regwrite_w && rd_w!=0 && rd_w==rs1_e.
- Otherwise fwd_a_e = 00.
- fwd_b_e is computed identically against rs2_e.
- MEM has priority over WB when both match.

Internal terms:
- mem_stall = dmem_req_m && !dmem_ready && state!=TIMEOUT.
- lw_stall = memtoreg_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
- if_wait = !imem_ready.

Output priority, highest first:
1. mem_stall: stall_f = stall_d = stall_e = stall_m = 1, flush_w = 1. All other flushes are 0; pcsrc_e and lw_stall are ignored while held.
2. pcsrc_e: flush_d = 1, flush_e = 1, stall_f = stall_d = 0. The redirect overrides lw_stall and if_wait.
3. lw_stall: stall_f = 1, stall_d = 1, flush_e = 1.
4. if_wait: stall_f = 1, flush_d = 1 (bubble into decode).
5. drop_pending && imem_ready: flush_d = 1, discarding the stale fetch.
- All unlisted outputs are 0.

drop_pending register:
- Set when pcsrc_e && if_wait && !mem_stall, i.e. a redirect occurs while the old fetch is outstanding.
- Cleared on the first cycle with imem_ready=1.
- Set has priority over clear in the same cycle only if imem_ready=0.

Data-memory FSM (states RUN, DWAIT, TIMEOUT):
- RUN -> DWAIT when mem_stall; wait_cnt <= 1.
- DWAIT, dmem_ready: -> RUN, wait_cnt <= 0.
- DWAIT, !dmem_ready: wait_cnt increments.
- DWAIT, wait_cnt reaches DMEM_TIMEOUT-1 with !dmem_ready: -> TIMEOUT; dmem_timeout <= 1.
- TIMEOUT: mem_stall is forced to 0 so the pipeline drains; dmem_timeout stays 1; the state is left only by reset.
- A single-cycle access (dmem_req_m && dmem_ready in the same cycle) causes no stall and no state change.
- wait_cnt width is $clog2(DMEM_TIMEOUT+1) and it never wraps.

Test Plan:
- Forwarding: rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1, rs1_e=5 -> fwd_a_e=10. Same with rd_m=0 -> fwd_a_e=01. rs2_e=0 with rd_w=0 -> fwd_b_e=00.
- Load-use: memtoreg_e=1, rd_e=3, rs2_d=3 -> stall_f=stall_d=flush_e=1 for exactly that cycle. Add pcsrc_e=1 in the same cycle -> flush_d=flush_e=1, stall_f=stall_d=0.
- Data wait: dmem_req_m=1 with dmem_ready low for 4 cycles, then high -> stall_f/d/e/m and flush_w high for 4 cycles, 0 on the 5th; state returns to RUN.
- Timeout with DMEM_TIMEOUT=8: hold dmem_ready=0 -> dmem_timeout rises after 8 stalled cycles and stalls drop. dmem_timeout remains 1 until rst_n pulses low.
- Redirect during fetch wait: imem_ready=0, pcsrc_e=1 for 1 cycle, imem_ready=1 two cycles later -> flush_d=1 on the imem_ready cycle, then drop_pending=0.
- Async reset mid-DWAIT: drop rst_n between clock edges -> flush_d/e/w=1 and stalls=0 immediately. After release: state RUN, wait_cnt 0, dmem_timeout 0.
